// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between two FIFOs, the arbiter and a byte serializer.
// master = arbiter side, slave = FIFO/serializer side.
interface fifo_rd_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  arb_en;
  logic                  f0_empty;
  logic [DATA_WIDTH-1:0] f0_rdata;
  logic                  f0_inc;
  logic                  f1_empty;
  logic [DATA_WIDTH-1:0] f1_rdata;
  logic                  f1_inc;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  grant_id;
  logic                  arb_busy;

  modport master (
    input  arb_en,
    input  f0_empty,
    input  f0_rdata,
    input  f1_empty,
    input  f1_rdata,
    input  tx_busy,
    output f0_inc,
    output f1_inc,
    output tx_data,
    output tx_valid,
    output grant_id,
    output arb_busy
  );

  modport slave (
    output arb_en,
    output f0_empty,
    output f0_rdata,
    output f1_empty,
    output f1_rdata,
    output tx_busy,
    input  f0_inc,
    input  f1_inc,
    input  tx_data,
    input  tx_valid,
    input  grant_id,
    input  arb_busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter moving single bytes from two FIFOs to a serializer.
// Outputs are decoded from the state, grant and data registers only.
module fifo_rd_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               r_clk,
  input  logic               r_rst,
  fifo_rd_arbiter_if.master  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] POP  = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;

  logic [2:0]            r_state;
  logic                  r_last;
  logic                  r_gid;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_req0;
  logic w_req1;
  logic w_grant;
  logic w_sel;

  assign w_req0  = ~bus.f0_empty;
  assign w_req1  = ~bus.f1_empty;
  assign w_grant = bus.arb_en & ~bus.tx_busy
                 & (w_req0 | w_req1);

  // both requesting: take the one not served last
  assign w_sel = (w_req0 & w_req1) ? ~r_last : w_req1;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gid   <= 1'b0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_gid   <= w_sel;
            r_last  <= w_sel;
            r_state <= POP;
          end
        end
        POP: begin
          r_data  <= r_gid ? bus.f1_rdata
                           : bus.f0_rdata;
          r_state <= SEND;
        end
        SEND: r_state <= HOLD;
        HOLD: r_state <= WAIT;
        WAIT: begin
          if (!bus.tx_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.f0_inc   = (r_state == POP) & ~r_gid;
  assign bus.f1_inc   = (r_state == POP) &  r_gid;
  assign bus.tx_valid = (r_state == SEND);
  assign bus.tx_data  = r_data;
  assign bus.grant_id = r_gid;
  assign bus.arb_busy = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed scoreboard bench for fifo_rd_arbiter.
// FIFO and serializer are small behavioural models.
module tb_fifo_rd_arbiter;

  typedef struct {
    logic       gid;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;

  fifo_rd_arbiter_if #(.DATA_WIDTH(8)) bus ();

  fifo_rd_arbiter #(.DATA_WIDTH(8)) dut (
    .r_clk (clk),
    .r_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_cmp;
  int n_err;
  int cyc;
  int last_inc;
  int busy_cnt;
  int busy_len;
  int n_inc0;
  int n_inc1;
  bit pend0;
  bit pend1;
  bit force_busy;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.f0_empty = (q0.size() == 0);
    bus.f1_empty = (q1.size() == 0);
    bus.f0_rdata = (q0.size() != 0) ? q0[0] : 8'h00;
    bus.f1_rdata = (q1.size() != 0) ? q1[0] : 8'h00;
    bus.tx_busy  = force_busy | (busy_cnt > 0);
  endtask

  task automatic push_exp(input logic g, input logic [7:0] d);
    exp_t e;
    e.gid  = g;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    // FIFO pointer moved at the edge that closed POP
    if (pend0 && q0.size() != 0) void'(q0.pop_front());
    if (pend1 && q1.size() != 0) void'(q1.pop_front());
    pend0 = 1'b0;
    pend1 = 1'b0;
    chk("inc_excl", bus.f0_inc & bus.f1_inc, 0);
    if (bus.f0_inc | bus.f1_inc) begin
      if (last_inc >= 0)
        chk("inc_spacing", (cyc - last_inc) >= 5, 1);
      last_inc = cyc;
    end
    if (bus.f0_inc) begin
      n_inc0++;
      pend0 = 1'b1;
    end
    if (bus.f1_inc) begin
      n_inc1++;
      pend1 = 1'b1;
    end
    if (busy_cnt > 0) busy_cnt--;
    if (bus.tx_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_tx_valid", bus.tx_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("tx_data", bus.tx_data, e.data);
        chk("grant_id", bus.grant_id, e.gid);
      end
      busy_cnt = busy_len;
    end
    drive();
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!bus.tx_valid && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid_timeout", bus.tx_valid, 1);
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("sb_drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_f0_inc"},   bus.f0_inc,   0);
    chk({tag, "_f1_inc"},   bus.f1_inc,   0);
    chk({tag, "_tx_valid"}, bus.tx_valid, 0);
    chk({tag, "_tx_data"},  bus.tx_data,  0);
    chk({tag, "_arb_busy"}, bus.arb_busy, 0);
    chk({tag, "_grant_id"}, bus.grant_id, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    last_inc = -1;
    chk_reset_outs("reset");
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    last_inc = -1;
    busy_cnt = 0;
    busy_len = 3;
    n_inc0 = 0;
    n_inc1 = 0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    force_busy = 1'b0;
    rst = 1'b1;
    bus.arb_en = 1'b1;
    drive();

    // reset state
    do_reset();

    // single byte from FIFO 0 with latency checks
    q0.push_back(8'hA5);
    push_exp(1'b0, 8'hA5);
    drive();
    tick();
    chk("single_f0_inc_t1", bus.f0_inc, 1);
    chk("single_busy_t1", bus.arb_busy, 1);
    tick();
    chk("single_tx_valid_t2", bus.tx_valid, 1);
    wait_sb(40);
    repeat (6) tick();
    chk("single_idle", bus.arb_busy, 0);

    // round robin 0,1,0,1 from a fresh reset
    do_reset();
    busy_len = 3;
    q0.push_back(8'h11);
    q0.push_back(8'h11);
    q1.push_back(8'h22);
    q1.push_back(8'h22);
    push_exp(1'b0, 8'h11);
    push_exp(1'b1, 8'h22);
    push_exp(1'b0, 8'h11);
    push_exp(1'b1, 8'h22);
    drive();
    wait_sb(100);
    repeat (8) tick();

    // backpressure: serializer busy 10 cycles
    busy_len = 10;
    q0.push_back(8'h33);
    q1.push_back(8'h44);
    push_exp(1'b0, 8'h33);
    push_exp(1'b1, 8'h44);
    drive();
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_arb_busy", bus.arb_busy, 1);
      chk("bp_no_inc", bus.f0_inc | bus.f1_inc, 0);
    end
    tick();
    chk("bp_idle_again", bus.arb_busy, 0);
    tick();
    chk("bp_next_grant", bus.f1_inc, 1);
    wait_sb(60);
    repeat (14) tick();

    // arb_en low holds off pending data
    busy_len = 4;
    bus.arb_en = 1'b0;
    q0.push_back(8'h55);
    q0.push_back(8'h77);
    drive();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("en_off_quiet",
          bus.f0_inc | bus.f1_inc | bus.tx_valid, 0);
    end
    // arb_en dropped during WAIT lets the transfer finish only
    bus.arb_en = 1'b1;
    push_exp(1'b0, 8'h55);
    wait_valid(20);
    tick();
    tick();
    chk("en_drop_in_wait", bus.arb_busy, 1);
    bus.arb_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("en_drop_no_grant", bus.f0_inc | bus.f1_inc, 0);
    end
    chk("en_drop_idle", bus.arb_busy, 0);
    chk("en_drop_pending", q0.size(), 1);

    // reset mid-WAIT with serializer busy
    bus.arb_en = 1'b1;
    busy_len = 6;
    push_exp(1'b0, 8'h77);
    drive();
    wait_valid(20);
    tick();
    tick();
    chk("rst_mid_wait_busy", bus.arb_busy, 1);
    rst = 1'b1;
    tick();
    last_inc = -1;
    chk_reset_outs("rst_mid_wait");
    rst = 1'b0;
    q0.push_back(8'h99);
    q1.push_back(8'h88);
    push_exp(1'b0, 8'h99);
    push_exp(1'b1, 8'h88);
    drive();
    wait_sb(80);
    repeat (10) tick();

    // tx_busy in IDLE blocks grants
    busy_len = 2;
    force_busy = 1'b1;
    q0.push_back(8'hAA);
    drive();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("busy_blocks", bus.f0_inc | bus.f1_inc, 0);
    end
    force_busy = 1'b0;
    push_exp(1'b0, 8'hAA);
    drive();
    wait_sb(30);
    repeat (6) tick();

    // both FIFOs empty for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty_quiet",
          bus.f0_inc | bus.f1_inc | bus.tx_valid, 0);
    end

    chk("total_inc0", n_inc0, 8);
    chk("total_inc1", n_inc1, 4);
    chk("sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
